fcs_engine: RTL and testbench
=============================

# fcs_engine

Parametrised CRC-32 (IEEE 802.3 FCS) engine for the gigabit-transceiver data path. It computes one independent CRC per lane over N_CH lanes that share one stream, processing BYTES bytes per lane per beat. Each beat uses a valid/ready handshake with start-of-frame and end-of-frame marking and a partial last beat. At end of frame it returns the finalised FCS and, optionally, a receive-side residue check.

## Interface
- N_CH, 2, number of lanes, each with its own CRC.
- BYTES, 2, bytes per lane per beat (1..8).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- s_data  in  8*BYTES*N_CH  lane i occupies s_data[i*8*BYTES +: 8*BYTES]; byte 0 is the low byte.
- s_valid  in  1  beat present.
- s_ready  out  1  beat accepted when s_valid & s_ready.
- s_sof  in  1  first beat of frame.
- s_eof  in  1  last beat of frame.
- s_nbytes  in  $clog2(BYTES)+1  valid low-order bytes per lane in an eof beat (0..BYTES); ignored on non-eof beats, which are always full.
- m_valid  out  1  result held.
- m_ready  in  1  result consumed when m_valid & m_ready.
- m_fcs  out  32*N_CH  finalised CRC per lane, lane i at [i*32 +: 32].
- m_ok  out  N_CH  residue-check pass per lane.

## Operation
- Algorithm: reflected CRC-32 with polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. Bytes are processed in order 0..BYTES-1, each byte LSB first.
- Each lane keeps a 32-bit state register `crc[i]`. The update is a single-cycle combinational fold over the valid bytes of the beat.
- Accepted beat with s_sof=1: fold starts from 0xFFFFFFFF.
  - This aborts any open frame silently; no result is produced for the aborted frame.
- Accepted beat with s_sof=0: fold starts from `crc[i]`.
- Accepted beat with s_eof=0: `crc[i]` takes the folded value.
- Accepted beat with s_eof=1:
  - Only s_nbytes bytes are folded.
  - m_fcs[i] is loaded with folded ^ 0xFFFFFFFF.
  - m_ok[i] is loaded with (folded == 0xDEBB20E3).
  - m_valid is set.
  - `crc[i]` returns to 0xFFFFFFFF, so the next frame is correct even without s_sof.
- s_sof=1 with s_eof=1 is a single-beat frame. With s_nbytes=0, m_fcs = 0x00000000.
- Output stage is a one-entry register: s_ready = ~m_valid | m_ready (combinational).
- m_valid clears on consume unless an eof beat is accepted in the same cycle, in which case the new result is loaded and m_valid stays 1.
- No beat is lost or duplicated under back-pressure. s_data and control must be held stable while s_valid & ~s_ready.
- After reset, `crc[i]` = 0xFFFFFFFF, so a first frame without s_sof is still computed correctly.

## Timing
- Reset values: m_valid=0, m_fcs=0, m_ok=0, every `crc[i]`=0xFFFFFFFF. s_ready=1 while reset is asserted and after release.
- Latency: result is visible on m_valid/m_fcs in the cycle after the eof beat is accepted.
- Throughput: one beat per cycle while m_ready=1 or no result is pending.
- m_fcs and m_ok are stable whenever m_valid=1 and the result has not yet been consumed.
- Reset mid-frame or with a result pending:
  - The partial frame and pending result are discarded.
  - The first post-reset frame is unaffected.

## Configuration
- FCS_CHECK_EN defined: residue comparator per lane is present; m_ok behaves as above.
- FCS_CHECK_EN undefined: no comparator is built; m_ok is tied to 0. m_fcs and all handshake behaviour are unchanged.

## Test plan
- Defaults (N_CH=2, BYTES=2), lane 0 ASCII "123456789", lane 1 identical:
  - Stimulus: 5 beats, sof on beat 1, eof on beat 5 with s_nbytes=1.
  - Response: one cycle later m_valid=1, both lanes m_fcs=0xCBF43926, m_ok=0.
- Residue check (FCS_CHECK_EN defined):
  - Stimulus: "123456789" followed by bytes 26 39 F4 CB (13 bytes, last beat s_nbytes=1).
  - Response: m_ok=2'b11, m_fcs=0x2144DF1C.
- Short frames:
  - Single beat, sof&eof, s_nbytes=1, byte 0x00: m_fcs=0xD202EF8D.
  - Single beat, sof&eof, s_nbytes=0: m_fcs=0x00000000.
- Back-pressure:
  - Stimulus: hold m_ready=0 with a result pending, then present the next frame's beats.
  - Response: s_ready=0 and the held result is stable.
  - Stimulus: raise m_ready together with an eof beat in the same cycle.
  - Response: the new result loads and m_valid stays 1; both results are observed exactly once.
- Abort:
  - Stimulus: sof, 2 beats of garbage, then a new sof followed by "123456789".
  - Response: exactly one result, 0xCBF43926.
- Async reset:
  - Stimulus: assert reset between clock edges mid-frame.
  - Response: m_valid drops to 0 immediately; the next clean frame gives 0xCBF43926.

Source files
------------

// File: rtl/fcs_engine.sv
// +--------------------------------------------------------------------------+
// | fcs_engine: per-lane CRC-32 (IEEE 802.3 FCS) with valid/ready framing.   |
// | Optional residue check enabled by defining FCS_CHECK_EN.  Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module fcs_engine #(
  parameter int N_CH  = 2,
  parameter int BYTES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [8*BYTES*N_CH-1:0]    s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_sof,
  input  logic                       s_eof,
  input  logic [$clog2(BYTES):0]     s_nbytes,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [32*N_CH-1:0]         m_fcs,
  output logic [N_CH-1:0]            m_ok
);

  localparam logic [31:0] C_POLY    = 32'hEDB88320;
  localparam logic [31:0] C_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] C_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ C_POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic [31:0]        crc_q [N_CH];
  logic [31:0]        fold_d [N_CH];
  logic [31:0]        acc;
  logic               m_valid_q;
  logic [32*N_CH-1:0] m_fcs_q;
  logic               accept;

  assign s_ready = ~m_valid_q | m_ready;
  assign accept  = s_valid & s_ready;
  assign m_valid = m_valid_q;
  assign m_fcs   = m_fcs_q;

  // Non-eof beats are always full; eof beats fold only the low s_nbytes bytes.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc = s_sof ? C_INIT : crc_q[i];
      for (int j = 0; j < BYTES; j++) begin
        if (!s_eof || (j < int'(s_nbytes))) begin
          acc = crc_byte(acc, s_data[(i*BYTES+j)*8 +: 8]);
        end
      end
      fold_d[i] = acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        crc_q[i] <= C_INIT;
      end
      m_valid_q <= 1'b0;
      m_fcs_q   <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_CH; i++) begin
          crc_q[i] <= s_eof ? C_INIT : fold_d[i];
        end
      end
      if (accept && s_eof) begin
        m_valid_q <= 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          m_fcs_q[i*32 +: 32] <= fold_d[i] ^ C_INIT;
        end
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

`ifdef FCS_CHECK_EN
  logic [N_CH-1:0] m_ok_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ok_q <= '0;
    end else if (accept && s_eof) begin
      for (int i = 0; i < N_CH; i++) begin
        m_ok_q[i] <= (fold_d[i] == C_RESIDUE);
      end
    end
  end

  assign m_ok = m_ok_q;
`else
  assign m_ok = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fcs_engine.sv
// Directed self-checking bench for fcs_engine (N_CH=2, BYTES=2, both lanes fed identical bytes).
`default_nettype none

module tb_fcs_engine;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [31:0] s_data   = '0;
  logic        s_valid  = 1'b0;
  logic        s_ready;
  logic        s_sof    = 1'b0;
  logic        s_eof    = 1'b0;
  logic [1:0]  s_nbytes = '0;
  logic        m_valid;
  logic        m_ready  = 1'b0;
  logic [63:0] m_fcs;
  logic [1:0]  m_ok;

  int checks   = 0;
  int failures = 0;
  int hs       = 0;
  int h0       = 0;

`ifdef FCS_CHECK_EN
  localparam logic [1:0] OK_RES = 2'b11;
`else
  localparam logic [1:0] OK_RES = 2'b00;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_valid && m_ready) hs <= hs + 1;
  end

  fcs_engine #(.N_CH(2), .BYTES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sof    (s_sof),
    .s_eof    (s_eof),
    .s_nbytes (s_nbytes),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_fcs    (m_fcs),
    .m_ok     (m_ok)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called shortly after a rising edge; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [7:0] b0, input logic [7:0] b1,
                      input logic sof, input logic eof, input logic [1:0] nb);
    int k;
    k = 0;
    s_data = {b1, b0, b1, b0};
    s_sof = sof; s_eof = eof; s_nbytes = nb; s_valid = 1'b1;
    #1;
    while (!s_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 40) chk("beat_accept_timeout", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  task automatic send_123(input logic sof);
    beat(8'h31, 8'h32, sof,  1'b0, 2'd0);
    beat(8'h33, 8'h34, 1'b0, 1'b0, 2'd0);
    beat(8'h35, 8'h36, 1'b0, 1'b0, 2'd0);
    beat(8'h37, 8'h38, 1'b0, 1'b0, 2'd0);
    beat(8'h39, 8'hEE, 1'b0, 1'b1, 2'd1);
  endtask

  task automatic consume(input string tag, input logic [31:0] fcs, input logic [1:0] ok);
    chk({tag, "_valid"}, 64'(m_valid), 64'd1);
    chk({tag, "_fcs"},   m_fcs, {fcs, fcs});
    chk({tag, "_ok"},    64'(m_ok), 64'(ok));
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk({tag, "_drained"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_fcs",   m_fcs, 64'd0);
    chk("rst_m_ok",    64'(m_ok), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Check value, with latency: m_valid is up one cycle after the eof beat
    send_123(1'b1);
    consume("check_value", 32'hCBF43926, 2'b00);

    // Next frame without sof after a completed frame
    send_123(1'b0);
    consume("no_sof", 32'hCBF43926, 2'b00);

    // Residue frame: "123456789" + 26 39 F4 CB
    beat(8'h31, 8'h32, 1'b1, 1'b0, 2'd0);
    beat(8'h33, 8'h34, 1'b0, 1'b0, 2'd0);
    beat(8'h35, 8'h36, 1'b0, 1'b0, 2'd0);
    beat(8'h37, 8'h38, 1'b0, 1'b0, 2'd0);
    beat(8'h39, 8'h26, 1'b0, 1'b0, 2'd0);
    beat(8'h39, 8'hF4, 1'b0, 1'b0, 2'd0);
    beat(8'hCB, 8'h77, 1'b0, 1'b1, 2'd1);
    consume("residue", 32'h2144DF1C, OK_RES);

    // Short frames
    beat(8'h00, 8'hA5, 1'b1, 1'b1, 2'd1);
    consume("one_byte", 32'hD202EF8D, 2'b00);
    beat(8'h55, 8'h66, 1'b1, 1'b1, 2'd0);
    consume("zero_bytes", 32'h00000000, 2'b00);

    // Back-pressure: result pending, next single-beat frame waits
    send_123(1'b1);
    h0 = hs;
    s_data = {8'hA5, 8'h00, 8'hA5, 8'h00};
    s_sof = 1'b1; s_eof = 1'b1; s_nbytes = 2'd1; s_valid = 1'b1;
    #1;
    chk("bp_ready_low", 64'(s_ready), 64'd0);
    repeat (3) begin @(posedge clk); end
    #1;
    chk("bp_ready_held",  64'(s_ready), 64'd0);
    chk("bp_valid_held",  64'(m_valid), 64'd1);
    chk("bp_fcs_stable",  m_fcs, {2{32'hCBF43926}});
    chk("bp_no_consume",  64'(hs), 64'(h0));
    m_ready = 1'b1;
    #1;
    chk("bp_ready_high", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0; m_ready = 1'b0;
    chk("bp_first_once", 64'(hs), 64'(h0 + 1));
    consume("bp_second", 32'hD202EF8D, 2'b00);
    repeat (3) begin @(posedge clk); end
    #1;
    chk("bp_both_once", 64'(hs), 64'(h0 + 2));
    chk("bp_idle",      64'(m_valid), 64'd0);

    // Abort: open frame replaced by a new sof
    beat(8'hAA, 8'hBB, 1'b1, 1'b0, 2'd0);
    beat(8'hCC, 8'hDD, 1'b0, 1'b0, 2'd0);
    chk("abort_no_result", 64'(m_valid), 64'd0);
    h0 = hs;
    send_123(1'b1);
    consume("abort", 32'hCBF43926, 2'b00);
    chk("abort_one_result", 64'(hs), 64'(h0 + 1));

    // Async reset with a result pending
    beat(8'h00, 8'h00, 1'b1, 1'b1, 2'd1);
    chk("pend_before_rst", 64'(m_valid), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid_drop", 64'(m_valid), 64'd0);
    chk("arst_fcs_clear",  m_fcs, 64'd0);
    chk("arst_ready",      64'(s_ready), 64'd1);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-frame; following frame sent without sof
    beat(8'hAA, 8'hBB, 1'b1, 1'b0, 2'd0);
    beat(8'hCC, 8'hDD, 1'b0, 1'b0, 2'd0);
    #3 reset = 1'b1;
    #1;
    chk("arst_mid_valid", 64'(m_valid), 64'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    send_123(1'b0);
    consume("post_reset", 32'hCBF43926, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
